// File: rtl/vga_pkg.sv
// Shared VGA timing constants, count width and small enums used by the
// bouncing-box video source.
package vga_pkg;

  localparam int unsigned TOTAL_COLS  = 800;
  localparam int unsigned TOTAL_ROWS  = 525;
  localparam int unsigned ACTIVE_COLS = 640;
  localparam int unsigned ACTIVE_ROWS = 480;
  localparam int unsigned COUNT_W     = 10;

  // Colour cycled on every bounce.
  typedef enum logic [1:0] {
    RED = 2'd0,
    GRN = 2'd1,
    BLU = 2'd2
  } colour_t;

  // Axis direction: 0 = increasing coordinate, 1 = decreasing coordinate.
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

endpackage

// File: rtl/bounce_axis.sv
// Single-axis position/direction register. On each i_Update the position
// moves p_STEP toward the current direction, clamps at 0 or
// p_EXTENT-p_SIZE, and flips direction on reaching either limit.
// o_Bounce is high in the update cycle that causes a flip.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int unsigned p_EXTENT = ACTIVE_COLS,
  parameter int unsigned p_SIZE   = 32,
  parameter int unsigned p_STEP   = 2
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Update,
  output logic [COUNT_W-1:0] o_Pos,
  output logic               o_Bounce
);

  localparam logic [COUNT_W:0] c_LIMIT = (COUNT_W+1)'(p_EXTENT - p_SIZE);
  localparam logic [COUNT_W:0] c_STEP  = (COUNT_W+1)'(p_STEP);

  logic [COUNT_W-1:0] r_Pos;
  logic [COUNT_W-1:0] w_Next_Pos;
  dir_t               r_Dir;
  dir_t               w_Next_Dir;
  logic               w_Bounce;
  logic [COUNT_W:0]   w_Pos_Ext;
  logic [COUNT_W:0]   w_Pos_Inc;

  assign w_Pos_Ext = {1'b0, r_Pos};
  assign w_Pos_Inc = w_Pos_Ext + c_STEP;

  // Next position/direction for a step, with reflection at both limits.
  always_comb begin
    w_Next_Pos = r_Pos;
    w_Next_Dir = r_Dir;
    w_Bounce   = 1'b0;
    if (r_Dir == DIR_INC) begin
      if (w_Pos_Inc >= c_LIMIT) begin
        w_Next_Pos = c_LIMIT[COUNT_W-1:0];
        w_Next_Dir = DIR_DEC;
        w_Bounce   = 1'b1;
      end else begin
        w_Next_Pos = w_Pos_Inc[COUNT_W-1:0];
      end
    end else begin
      if (w_Pos_Ext <= c_STEP) begin
        w_Next_Pos = '0;
        w_Next_Dir = DIR_INC;
        w_Bounce   = 1'b1;
      end else begin
        w_Next_Pos = r_Pos - c_STEP[COUNT_W-1:0];
      end
    end
  end

  // Position/direction register, advanced only on a frame update.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Pos <= '0;
      r_Dir <= DIR_INC;
    end else if (i_Update) begin
      r_Pos <= w_Next_Pos;
      r_Dir <= w_Next_Dir;
    end
  end

  assign o_Pos    = r_Pos;
  assign o_Bounce = i_Update & w_Bounce;

endmodule

// File: rtl/vga_bounce_box.sv
// Bouncing-square video source placed ahead of the VGA sync/porch stage.
// Two-stage pipeline: stage 1 registers counts and active/in-box compares,
// stage 2 registers the RGB select. Box moves once per frame on the first
// blanking line and cycles RED->GRN->BLU on any bounce.
// Optional macro VGA_BORDER_EN: paints a one-pixel white border around the
// active area, taking priority over the box.
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int unsigned c_VIDEO_WIDTH = 3,
  parameter int unsigned c_ACTIVE_COLS = ACTIVE_COLS,
  parameter int unsigned c_ACTIVE_ROWS = ACTIVE_ROWS,
  parameter int unsigned c_BOX_SIZE    = 32,
  parameter int unsigned c_STEP        = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic [COUNT_W-1:0]       i_Col_Count,
  input  logic [COUNT_W-1:0]       i_Row_Count,
  input  logic                     i_Pause,
  output logic [c_VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [c_VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [c_VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic [COUNT_W-1:0]       o_Col_Count,
  output logic [COUNT_W-1:0]       o_Row_Count,
  output logic                     o_Frame_Tick
);

  localparam logic [COUNT_W:0]   c_COLS_EXT   = (COUNT_W+1)'(c_ACTIVE_COLS);
  localparam logic [COUNT_W:0]   c_ROWS_EXT   = (COUNT_W+1)'(c_ACTIVE_ROWS);
  localparam logic [COUNT_W:0]   c_BOX_EXT    = (COUNT_W+1)'(c_BOX_SIZE);
  localparam logic [COUNT_W-1:0] c_UPDATE_ROW = COUNT_W'(c_ACTIVE_ROWS);

  logic [COUNT_W:0]   w_Col_Ext;
  logic [COUNT_W:0]   w_Row_Ext;
  logic [COUNT_W-1:0] w_X_Pos;
  logic [COUNT_W-1:0] w_Y_Pos;
  logic [COUNT_W:0]   w_X_Ext;
  logic [COUNT_W:0]   w_Y_Ext;
  logic               w_Active;
  logic               w_In_Box;
  logic               w_Update;
  logic               w_Move;
  logic               w_Bounce_X;
  logic               w_Bounce_Y;

  colour_t            r_Colour;
  colour_t            w_Colour_Next;

  logic [COUNT_W-1:0] r_Col1;
  logic [COUNT_W-1:0] r_Row1;
  logic               r_Active1;
  logic               r_In_Box1;
  logic               r_Tick1;
  logic [COUNT_W-1:0] r_Col2;
  logic [COUNT_W-1:0] r_Row2;
  logic               r_Tick2;

  logic [c_VIDEO_WIDTH-1:0] w_Red;
  logic [c_VIDEO_WIDTH-1:0] w_Grn;
  logic [c_VIDEO_WIDTH-1:0] w_Blu;
  logic [c_VIDEO_WIDTH-1:0] r_Red2;
  logic [c_VIDEO_WIDTH-1:0] r_Grn2;
  logic [c_VIDEO_WIDTH-1:0] r_Blu2;

  assign w_Col_Ext = {1'b0, i_Col_Count};
  assign w_Row_Ext = {1'b0, i_Row_Count};
  assign w_X_Ext   = {1'b0, w_X_Pos};
  assign w_Y_Ext   = {1'b0, w_Y_Pos};

  assign w_Active = (w_Col_Ext < c_COLS_EXT) && (w_Row_Ext < c_ROWS_EXT);
  assign w_In_Box = (w_Col_Ext >= w_X_Ext) && (w_Col_Ext < w_X_Ext + c_BOX_EXT) &&
                    (w_Row_Ext >= w_Y_Ext) && (w_Row_Ext < w_Y_Ext + c_BOX_EXT);

  // First cycle of the first blanking line: position never moves mid-picture.
  assign w_Update = (i_Col_Count == '0) && (i_Row_Count == c_UPDATE_ROW);
  assign w_Move   = w_Update && !i_Pause;

  bounce_axis #(
    .p_EXTENT (c_ACTIVE_COLS),
    .p_SIZE   (c_BOX_SIZE),
    .p_STEP   (c_STEP)
  ) u_axis_x (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Update (w_Move),
    .o_Pos    (w_X_Pos),
    .o_Bounce (w_Bounce_X)
  );

  bounce_axis #(
    .p_EXTENT (c_ACTIVE_ROWS),
    .p_SIZE   (c_BOX_SIZE),
    .p_STEP   (c_STEP)
  ) u_axis_y (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Update (w_Move),
    .o_Pos    (w_Y_Pos),
    .o_Bounce (w_Bounce_Y)
  );

  // Colour state register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Colour <= RED;
    end else begin
      r_Colour <= w_Colour_Next;
    end
  end

  // Colour advance: a corner hit ORs both flags, so it steps only once.
  always_comb begin
    w_Colour_Next = r_Colour;
    if (w_Bounce_X || w_Bounce_Y) begin
      case (r_Colour)
        RED:     w_Colour_Next = GRN;
        GRN:     w_Colour_Next = BLU;
        default: w_Colour_Next = RED;
      endcase
    end
  end

`ifdef VGA_BORDER_EN
  logic w_Border;
  logic r_Border1;

  assign w_Border = (i_Col_Count == '0) || (w_Col_Ext == c_COLS_EXT - 1'b1) ||
                    (i_Row_Count == '0) || (w_Row_Ext == c_ROWS_EXT - 1'b1);

  // Border flag travels alongside the stage-1 compares.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Border1 <= 1'b0;
    end else begin
      r_Border1 <= w_Border;
    end
  end
`endif

  // Stage 1: counts, compares and frame-update marker.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Col1    <= '0;
      r_Row1    <= '0;
      r_Active1 <= 1'b0;
      r_In_Box1 <= 1'b0;
      r_Tick1   <= 1'b0;
    end else begin
      r_Col1    <= i_Col_Count;
      r_Row1    <= i_Row_Count;
      r_Active1 <= w_Active;
      r_In_Box1 <= w_In_Box;
      r_Tick1   <= w_Update;
    end
  end

  // Pixel colour select; border assignment comes last so it wins over the box.
  always_comb begin
    w_Red = '0;
    w_Grn = '0;
    w_Blu = '0;
    if (r_Active1) begin
      if (r_In_Box1) begin
        case (r_Colour)
          RED:     w_Red = '1;
          GRN:     w_Grn = '1;
          BLU:     w_Blu = '1;
          default: ;
        endcase
      end
`ifdef VGA_BORDER_EN
      if (r_Border1) begin
        w_Red = '1;
        w_Grn = '1;
        w_Blu = '1;
      end
`endif
    end
  end

  // Stage 2: registered video and delayed counts.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Col2 <= '0;
      r_Row2 <= '0;
      r_Tick2 <= 1'b0;
      r_Red2 <= '0;
      r_Grn2 <= '0;
      r_Blu2 <= '0;
    end else begin
      r_Col2 <= r_Col1;
      r_Row2 <= r_Row1;
      r_Tick2 <= r_Tick1;
      r_Red2 <= w_Red;
      r_Grn2 <= w_Grn;
      r_Blu2 <= w_Blu;
    end
  end

  assign o_Red_Video  = r_Red2;
  assign o_Grn_Video  = r_Grn2;
  assign o_Blu_Video  = r_Blu2;
  assign o_Col_Count  = r_Col2;
  assign o_Row_Count  = r_Row2;
  assign o_Frame_Tick = r_Tick2;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: reset state, latency, motion,
// bounce/colour sequencing, corner hit, pause, out-of-range counts and
// mid-frame reset. Expected values are hand-computed for default parameters.
module tb_vga_bounce_box;

  localparam logic [8:0] K_BLACK = 9'h000;
  localparam logic [8:0] K_RED   = 9'h1C0;
  localparam logic [8:0] K_GRN   = 9'h038;
  localparam logic [8:0] K_BLU   = 9'h007;
  localparam logic [8:0] K_WHITE = 9'h1FF;
`ifdef VGA_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic       clk;
  logic       i_Rst;
  logic [9:0] i_Col_Count;
  logic [9:0] i_Row_Count;
  logic       i_Pause;
  logic [2:0] o_Red_Video;
  logic [2:0] o_Grn_Video;
  logic [2:0] o_Blu_Video;
  logic [9:0] o_Col_Count;
  logic [9:0] o_Row_Count;
  logic       o_Frame_Tick;
  logic [8:0] rgb;

  int n_checks = 0;
  int n_errors = 0;

  assign rgb = {o_Red_Video, o_Grn_Video, o_Blu_Video};

  vga_bounce_box dut (
    .i_Clk        (clk),
    .i_Rst        (i_Rst),
    .i_Col_Count  (i_Col_Count),
    .i_Row_Count  (i_Row_Count),
    .i_Pause      (i_Pause),
    .o_Red_Video  (o_Red_Video),
    .o_Grn_Video  (o_Grn_Video),
    .o_Blu_Video  (o_Blu_Video),
    .o_Col_Count  (o_Col_Count),
    .o_Row_Count  (o_Row_Count),
    .o_Frame_Tick (o_Frame_Tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Border pixels override the base expectation when the border is built.
  function automatic logic [8:0] px(input int c, input int r, input logic [8:0] base);
    if (BORDER && c < 640 && r < 480 && (c == 0 || c == 639 || r == 0 || r == 479))
      return K_WHITE;
    return base;
  endfunction

  // Present counts for one clock; returns 1 time unit after the edge.
  task automatic drive(input logic [9:0] c, input logic [9:0] r);
    i_Col_Count = c;
    i_Row_Count = r;
    @(posedge clk);
    #1;
  endtask

  // Render one pixel through the 2-stage pipeline and compare its colour.
  task automatic probe(input string tag, input int c, input int r, input logic [8:0] base);
    drive(10'(c), 10'(r));
    drive(10'd700, 10'd0);
    check(tag, rgb, px(c, r, base));
  endtask

  // Issue n frame-update cycles and count the ticks seen.
  task automatic run_updates(input int n, output int ticks);
    ticks = 0;
    repeat (n) begin
      drive(10'd0, 10'd480);
      ticks += int'(o_Frame_Tick);
      drive(10'd700, 10'd0);
      ticks += int'(o_Frame_Tick);
      drive(10'd700, 10'd0);
      ticks += int'(o_Frame_Tick);
    end
  endtask

  int ticks;
  int s_col [9] = '{0, 31, 32, 0, 0, 31, 640, 639, 15};
  int s_row [9] = '{0, 0, 0, 31, 32, 31, 0, 0, 15};
  logic [8:0] s_exp [9] = '{K_RED, K_RED, K_BLACK, K_RED, K_BLACK, K_RED,
                            K_BLACK, K_BLACK, K_RED};

  initial begin
    i_Rst = 1'b1;
    i_Pause = 1'b0;
    i_Col_Count = '0;
    i_Row_Count = '0;

    // Reset state, with an update-position count applied during reset.
    drive(10'd0, 10'd480);
    drive(10'd0, 10'd480);
    drive(10'd0, 10'd480);
    check("rst_rgb", rgb, K_BLACK);
    check("rst_col", o_Col_Count, 0);
    check("rst_row", o_Row_Count, 0);
    check("rst_tick", o_Frame_Tick, 0);

    // Stream pixels from the first frame; output lags input by 2 edges.
    i_Rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) drive(10'(s_col[i]), 10'(s_row[i]));
      else       drive(10'd700, 10'd0);
      if (i == 0) begin
        check("post_rst_blank", rgb, K_BLACK);
      end else begin
        check($sformatf("lat_col%0d", i - 1), o_Col_Count, s_col[i - 1]);
        check($sformatf("lat_row%0d", i - 1), o_Row_Count, s_row[i - 1]);
        check($sformatf("px%0d", i - 1), rgb, px(s_col[i - 1], s_row[i - 1], s_exp[i - 1]));
      end
    end
    check("tick_idle", o_Frame_Tick, 0);

    // First frame update with tick timing.
    drive(10'd0, 10'd480);
    check("tick_e1", o_Frame_Tick, 0);
    drive(10'd700, 10'd0);
    check("tick_e2", o_Frame_Tick, 1);
    check("tick_row", o_Row_Count, 480);
    check("tick_col", o_Col_Count, 0);
    drive(10'd700, 10'd0);
    check("tick_e3", o_Frame_Tick, 0);
    probe("u1_1_1", 1, 1, K_BLACK);
    probe("u1_2_2", 2, 2, K_RED);
    probe("u1_33_33", 33, 33, K_RED);
    probe("u1_34_34", 34, 34, K_BLACK);

    // Update 224: Y reaches 448 and bounces -> GRN.
    run_updates(223, ticks);
    check("ticks_223", ticks, 223);
    probe("u224_box", 448, 448, K_GRN);
    probe("u224_left", 447, 448, K_BLACK);

    // Update 304: X reaches 608 and bounces -> BLU; Y=288 moving up.
    run_updates(80, ticks);
    check("ticks_80", ticks, 80);
    probe("u304_box", 608, 288, K_BLU);
    probe("u304_left", 607, 288, K_BLACK);
    probe("u304_far", 639, 319, K_BLU);

    // Update 305: both axes step backwards.
    run_updates(1, ticks);
    probe("u305_box", 606, 286, K_BLU);
    probe("u305_out", 638, 286, K_BLACK);

    // Paused frames: ticks continue, nothing moves.
    i_Pause = 1'b1;
    run_updates(5, ticks);
    i_Pause = 1'b0;
    check("pause_ticks", ticks, 5);
    probe("pause_box", 606, 286, K_BLU);
    probe("pause_out", 604, 284, K_BLACK);

    // Out-of-range column on the update row must not trigger an update.
    drive(10'd800, 10'd480);
    drive(10'd700, 10'd0);
    check("oor_tick1", o_Frame_Tick, 0);
    drive(10'd700, 10'd0);
    check("oor_tick2", o_Frame_Tick, 0);
    probe("oor_box", 606, 286, K_BLU);

    // Update 4255: X=2 moving left, Y=446 moving down, 31 bounces -> GRN.
    run_updates(3950, ticks);
    check("ticks_3950", ticks, 3950);
    probe("u4255_box", 2, 446, K_GRN);
    probe("u4255_out", 1, 446, K_BLACK);

    // Update 4256: corner hit, single colour advance GRN -> BLU.
    run_updates(1, ticks);
    probe("corner_box", 0, 448, K_BLU);
    probe("corner_out", 0, 447, K_BLACK);

    // Update 4257: both directions reversed.
    run_updates(1, ticks);
    probe("post_corner_box", 2, 446, K_BLU);
    probe("post_corner_out", 1, 446, K_BLACK);

    // Mid-frame reset with box pixels in flight.
    drive(10'd2, 10'd446);
    drive(10'd3, 10'd447);
    check("pre_rst_px", rgb, K_BLU);
    i_Rst = 1'b1;
    drive(10'd300, 10'd200);
    check("midrst_e1", rgb, K_BLACK);
    check("midrst_col", o_Col_Count, 0);
    i_Rst = 1'b0;
    drive(10'd301, 10'd200);
    check("midrst_e2", rgb, K_BLACK);
    probe("midrst_origin", 0, 0, K_RED);
    probe("midrst_inner", 16, 16, K_RED);
    probe("midrst_old", 2, 446, K_BLACK);
    probe("edge_0_100", 0, 100, K_BLACK);
    probe("edge_639_479", 639, 479, K_BLACK);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
